// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner and single-outstanding instruction fetcher
//
// Keeps the PC, issues one instruction-memory request at a time, applies
// branch redirects, drops stale responses, and presents fetched words to
// decode through a one-entry valid/ready output register.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   redirect_valid/pc    taken-branch pulse and target
//   imem_req_*           fetch request (valid/ready, word-aligned address)
//   imem_rsp_*           fetch response (valid, instruction data)
//   if_valid/pc/instr    output slot towards decode
//   if_ready             decode accepts the slot
//   fetch_misalign       sticky: a redirect target was not 4-byte aligned
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic        kill_q, kill_n;       // one stale response still to be dropped
  logic        halt_q, halt_n;       // enter S_HALT once the stale response drains
  logic        hold_q, hold_n;       // request shown last cycle but not accepted
  logic [31:0] req_addr_q, req_addr_n;
  logic        if_valid_q, if_valid_n;
  logic [31:0] if_pc_q, if_pc_n;
  logic [31:0] if_instr_q, if_instr_n;
  logic        misalign_q, misalign_n;

  logic        slot_free;
  logic        req_fire;
  logic        pending_after;
  logic        misalign_redir;
  logic [31:0] raw_addr;

  // A shown request must stay put until accepted, so it bypasses the
  // slot-free gate and keeps its latched address across redirects.
  assign slot_free      = !if_valid_q || if_ready;
  assign imem_req_valid = !rst && (state_q == S_REQ) && (hold_q || slot_free);
  assign raw_addr       = hold_q ? req_addr_q : pc_q;
  assign imem_req_addr  = {raw_addr[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign misalign_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // A request is in flight after this edge if we are still waiting for its
  // response, or one is being (or will later be) accepted from S_REQ.
  assign pending_after  = ((state_q == S_WAIT) && !imem_rsp_valid) || imem_req_valid;

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      halt_q     <= 1'b0;
      hold_q     <= 1'b0;
      req_addr_q <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      kill_q     <= kill_n;
      halt_q     <= halt_n;
      hold_q     <= hold_n;
      req_addr_q <= req_addr_n;
      if_valid_q <= if_valid_n;
      if_pc_q    <= if_pc_n;
      if_instr_q <= if_instr_n;
      misalign_q <= misalign_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    kill_n     = kill_q;
    halt_n     = halt_q;
    hold_n     = imem_req_valid && !imem_req_ready;
    req_addr_n = imem_req_addr;
    if_valid_n = if_valid_q;
    if_pc_n    = if_pc_q;
    if_instr_n = if_instr_q;
    misalign_n = misalign_q;

    if (if_valid_q && if_ready) begin
      if_valid_n = 1'b0;
      if_instr_n = NOP_INSTR;
    end

    if (redirect_valid) begin
      // Redirect overrides everything: any response this cycle is dropped
      // and the slot is flushed even if decode is taking it.
      pc_n       = redirect_pc;
      if_valid_n = 1'b0;
      if_instr_n = NOP_INSTR;
      kill_n     = pending_after;
      halt_n     = misalign_redir;
      if (misalign_redir) begin
        misalign_n = 1'b1;
      end
      if (pending_after) begin
        state_n = (imem_req_valid && !imem_req_ready) ? S_REQ : S_WAIT;
      end else begin
        state_n = misalign_redir ? S_HALT : S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_n  = 1'b0;
              halt_n  = 1'b0;
              state_n = halt_q ? S_HALT : S_REQ;
            end else begin
              if_valid_n = 1'b1;
              if_pc_n    = pc_q;
              if_instr_n = imem_rsp_data;
              pc_n       = pc_q + 32'd4;
              state_n    = S_REQ;
            end
          end
        end
        S_HALT: begin
          state_n = S_HALT;
        end
        default: begin
          state_n = S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        fetch_misalign;

  int errors = 0;
  int checks = 0;

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    #1;
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
    if (v) chk({tag, ".req_addr"}, imem_req_addr, a);
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    #1;
    chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
    if (v) chk({tag, ".if_pc"}, if_pc, p);
    chk({tag, ".if_instr"}, if_instr, i);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    if_ready = 1'b0;

    // Reset state
    step();
    step();
    chk_req("rst", 1'b0, 32'h0);
    chk("rst.req_addr", imem_req_addr, 32'h0);
    chk("rst.if_pc", if_pc, 32'h0);
    chk_slot("rst", 1'b0, 32'h0, NOP);
    chk("rst.misalign", {31'd0, fetch_misalign}, 32'd0);

    // Single-cycle memory, decode always ready
    rst = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    chk_req("a0", 1'b1, 32'h0);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0000;
    chk_req("w0", 1'b0, 32'h0);
    chk_slot("w0", 1'b0, 32'h0, NOP);
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("d0", 1'b1, 32'h0, 32'h1111_0000);
    chk_req("a4", 1'b1, 32'h4);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0004;
    chk_slot("gap", 1'b0, 32'h0, NOP);
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("d4", 1'b1, 32'h4, 32'h1111_0004);

    // Decode stall holds slot and blocks the next request
    if_ready = 1'b0;
    chk_req("stall0", 1'b0, 32'h0);
    step();
    chk_slot("stall1", 1'b1, 32'h4, 32'h1111_0004);
    chk_req("stall1", 1'b0, 32'h0);
    step();
    chk_slot("stall2", 1'b1, 32'h4, 32'h1111_0004);
    if_ready = 1'b1;
    chk_req("release", 1'b1, 32'h8);
    step();

    // Redirect to 0x100 while waiting for 0x8; late response dropped
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    chk_slot("rd1", 1'b0, 32'h0, NOP);
    step();
    redirect_valid = 1'b0;
    chk_req("rd1.wait", 1'b0, 32'h0);
    step();
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0008;
    chk_req("rd1.late", 1'b0, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("rd1.drop", 1'b0, 32'h0, NOP);
    chk_req("rd1.new", 1'b1, 32'h100);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_0100;
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("d100", 1'b1, 32'h100, 32'h2222_0100);
    chk_req("a104", 1'b1, 32'h104);
    step();

    // Redirect in the same cycle as the response for 0x104
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_0104;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
    chk_slot("rd2.drop", 1'b0, 32'h0, NOP);
    chk_req("rd2.new", 1'b1, 32'h200);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h4444_0200;
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("d200", 1'b1, 32'h200, 32'h4444_0200);

    // Misaligned redirect while request 0x204 is being accepted
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    chk_slot("mis.flush", 1'b0, 32'h0, NOP);
    chk("mis.flag", {31'd0, fetch_misalign}, 32'd1);
    chk_req("mis.wait", 1'b0, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_0204;
    step();
    imem_rsp_valid = 1'b0;
    chk_req("halt0", 1'b0, 32'h0);
    chk_slot("halt0", 1'b0, 32'h0, NOP);
    step();
    chk_req("halt1", 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    chk_req("a300", 1'b1, 32'h300);
    chk("a300.flag", {31'd0, fetch_misalign}, 32'd1);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h6666_0300;
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("d300", 1'b1, 32'h300, 32'h6666_0300);

    // Redirect while request 0x304 is shown but not accepted: it stays put
    imem_req_ready = 1'b0;
    chk_req("pend", 1'b1, 32'h304);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk_req("pend.hold", 1'b1, 32'h304);
    chk_slot("pend.flush", 1'b0, 32'h0, NOP);
    imem_req_ready = 1'b1;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0304;
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("pend.drop", 1'b0, 32'h0, NOP);
    chk_req("aFFC", 1'b1, 32'hFFFF_FFFC);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h7777_FFFC;
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("dFFC", 1'b1, 32'hFFFF_FFFC, 32'h7777_FFFC);
    chk_req("wrap", 1'b1, 32'h0);
    step();

    // Reset mid-wait; late responses ignored
    rst = 1'b1;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
    chk_req("rst2", 1'b0, 32'h0);
    chk("rst2.req_addr", imem_req_addr, 32'h0);
    chk("rst2.if_pc", if_pc, 32'h0);
    chk_slot("rst2", 1'b0, 32'h0, NOP);
    chk("rst2.misalign", {31'd0, fetch_misalign}, 32'd0);
    step();
    rst = 1'b0; imem_req_ready = 1'b0;
    chk_req("post", 1'b1, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    chk_slot("post.ign", 1'b0, 32'h0, NOP);
    chk_req("post.req", 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
